// File: rtl/mdu_iter_ctrl_if.sv
// Core <-> multiply/divide unit command and result bundle.
// master = core/decoder side, slave = mdu_iter_ctrl.
interface mdu_iter_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             mult_en;
  logic             div_en;
  logic             unsigned_instr;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wdata;
  logic             mf_rd;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output mult_en, div_en, unsigned_instr,
    output src_a, src_b,
    output hi_wr, lo_wr, wdata,
    output mf_rd, flush,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  mult_en, div_en, unsigned_instr,
    input  src_a, src_b,
    input  hi_wr, lo_wr, wdata,
    input  mf_rd, flush,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mdu_iter_ctrl.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO.
// Define MDU_FAST_MUL_EN for a single-cycle full-width multiply.
module mdu_iter_ctrl #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  mdu_iter_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             isdiv_q, isdiv_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic [WIDTH+1:0] ddiff;
  logic             dge;
  logic [WIDTH-1:0] quo, rem;

  assign sa    = ~bus.unsigned_instr & bus.src_a[WIDTH-1];
  assign sb    = ~bus.unsigned_instr & bus.src_b[WIDTH-1];
  assign mag_a = sa ? -bus.src_a : bus.src_a;
  assign mag_b = sb ? -bus.src_b : bus.src_b;

  assign msum = {1'b0, acc_q[W2-1:WIDTH]}
              + {1'b0, (acc_q[0] ? opb_q : '0)};

  // Remainder is provably < divisor, so the top bit of the
  // extended difference is a clean borrow flag.
  assign dshift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign ddiff  = {rem_q, acc_q[WIDTH-1]} - {2'b00, opb_q};
  assign dge    = ~ddiff[WIDTH+1];

  assign quo = acc_q[WIDTH-1:0];
  assign rem = rem_q[WIDTH-1:0];

`ifdef MDU_FAST_MUL_EN
  logic [W2-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{WIDTH{sa}}, bus.src_a};
  assign ext_b     = {{WIDTH{sb}}, bus.src_b};
  assign fast_prod = ext_a * ext_b;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    isdiv_d = isdiv_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.mult_en) begin
          isdiv_d = 1'b0;
          dz_d    = 1'b0;
`ifdef MDU_FAST_MUL_EN
          acc_d   = fast_prod;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          state_d = FIX;
`else
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          opb_d   = mag_a;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          cnt_d   = CNT_W'(WIDTH);
          state_d = MUL;
`endif
        end else if (bus.div_en) begin
          isdiv_d = 1'b1;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          rem_d   = '0;
          opb_d   = mag_b;
          cnt_d   = CNT_W'(WIDTH);
          if (bus.src_b == '0) begin
            dz_d    = 1'b1;
            acc_d   = {{WIDTH{1'b0}}, bus.src_a};
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = DIV;
          end
        end else begin
          if (bus.hi_wr) hi_d = bus.wdata;
          if (bus.lo_wr) lo_d = bus.wdata;
        end
      end
      MUL: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], dge};
          rem_d = dge ? ddiff[WIDTH:0] : dshift;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          done_d = 1'b1;
          if (!isdiv_q) begin
            {hi_d, lo_d} = negq_q ? -acc_q : acc_q;
          end else if (dz_q) begin
            lo_d = '1;
            hi_d = quo;
          end else begin
            lo_d = negq_q ? -quo : quo;
            hi_d = negr_q ? -rem : rem;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isdiv_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isdiv_q <= isdiv_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.stall = bus.busy & (bus.mult_en | bus.div_en
                   | bus.mf_rd | bus.hi_wr | bus.lo_wr);
endmodule

// File: tb/tb_mdu_iter_ctrl.sv
// Directed self-checking bench for mdu_iter_ctrl (WIDTH=32).
// Multiply latency expectation follows MDU_FAST_MUL_EN.
module tb_mdu_iter_ctrl;
  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  mdu_iter_ctrl_if #(.WIDTH(W)) bus ();

  mdu_iter_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.mult_en        = 1'b0;
    bus.div_en         = 1'b0;
    bus.unsigned_instr = 1'b0;
    bus.src_a          = '0;
    bus.src_b          = '0;
    bus.hi_wr          = 1'b0;
    bus.lo_wr          = 1'b0;
    bus.wdata          = '0;
    bus.mf_rd          = 1'b0;
    bus.flush          = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after E0.
  task automatic start(input logic m, input logic d,
                       input logic u,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.mult_en        = m;
    bus.div_en         = d;
    bus.unsigned_instr = u;
    bus.src_a          = a;
    bus.src_b          = b;
    @(posedge clk);
    @(negedge clk);
    clr();
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) break;
    end
  endtask

  task automatic run(input string tag,
                     input logic m, input logic d,
                     input logic u,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int lat,
                     input logic [31:0] ehi,
                     input logic [31:0] elo);
    int e;
    start(m, d, u, a, b);
    wait_done(e);
    chk({tag, "_lat"}, e, lat);
    chk({tag, "_hi"}, bus.hi, ehi);
    chk({tag, "_lo"}, bus.lo, elo);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    int e;
    int pulses;
    clr();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    if (MUL_LAT > 1)
      chk("multu_busy0", {31'b0, bus.busy}, 32'd1);
    wait_done(e);
    chk("multu_lat", e, MUL_LAT);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("multu_done", {31'b0, bus.done}, 32'd1);
    @(negedge clk);
    chk("multu_pulse", {31'b0, bus.done}, 32'd0);

    run("mult", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7,
        MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("div", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,
        DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu", 1'b0, 1'b1, 1'b1, 32'd100, 32'd7,
        DIV_LAT, 32'd2, 32'd14);
    run("divz", 1'b0, 1'b1, 1'b1, 32'd5, 32'd0,
        1, 32'd5, 32'hFFFF_FFFF);
    run("ovf", 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
        DIV_LAT, 32'd0, 32'h8000_0000);
    // Both enables: multiply wins (5*3, not 5/3).
    run("both", 1'b1, 1'b1, 1'b1, 32'd5, 32'd3,
        MUL_LAT, 32'd0, 32'd15);

    bus.hi_wr = 1'b1;
    bus.wdata = 32'h11;
    @(posedge clk);
    @(negedge clk);
    bus.hi_wr = 1'b0;
    bus.lo_wr = 1'b1;
    bus.wdata = 32'h22;
    @(posedge clk);
    @(negedge clk);
    clr();
    chk("wr_hi", bus.hi, 32'h11);
    chk("wr_lo", bus.lo, 32'h22);
    chk("wr_done", {31'b0, bus.done}, 32'd0);

    bus.flush   = 1'b1;
    bus.mult_en = 1'b1;
    bus.hi_wr   = 1'b1;
    bus.wdata   = 32'h99;
    @(posedge clk);
    @(negedge clk);
    clr();
    chk("iflush_busy", {31'b0, bus.busy}, 32'd0);
    chk("iflush_hi", bus.hi, 32'h11);

    start(1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {31'b0, bus.busy}, 32'd0);
    chk("flush_hi", bus.hi, 32'h11);
    chk("flush_lo", bus.lo, 32'h22);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("flush_nodone", pulses, 0);

    start(1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    bus.mf_rd = 1'b1;
    #1;
    chk("stall_mf", {31'b0, bus.stall}, 32'd1);
    @(negedge clk);
    chk("stall_hi", bus.hi, 32'h11);
    bus.mf_rd   = 1'b0;
    bus.mult_en = 1'b1;
    bus.src_a   = 32'd2;
    bus.src_b   = 32'd2;
    #1;
    chk("stall_mul", {31'b0, bus.stall}, 32'd1);
    repeat (3) @(negedge clk);
    clr();
    wait_done(e);
    chk("stall_lo", bus.lo, 32'd14);
    chk("stall_hi2", bus.hi, 32'd2);
    bus.mf_rd = 1'b1;
    #1;
    chk("stall_after", {31'b0, bus.stall}, 32'd0);
    @(negedge clk);
    clr();

    start(1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_hi", bus.hi, 32'd0);
    chk("mrst_lo", bus.lo, 32'd0);
    chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mrst_done", {31'b0, bus.done}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("mrst_nodone", pulses, 0);
    run("m67", 1'b1, 1'b0, 1'b0, 32'd6, 32'd7,
        MUL_LAT, 32'd0, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
